// File: rtl/reorder_buffer_mp.sv
`default_nettype none
// ============================================================================
// Module : reorder_buffer_mp
// Brief  : Multi-port reorder buffer with in-order retire and full flush.
//          Optional macro ROB_WB_BYPASS_EN: head writeback commits same cycle.
// Rev    : 1.0
// ============================================================================
module reorder_buffer_mp #(
    parameter int DEPTH_W = 4,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int N_WB    = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [TAG_W-1:0]       push_tag,
    input  logic [ADDR_W-1:0]      push_addr,
    input  logic [N_WB-1:0]        wb_valid,
    input  logic [N_WB*TAG_W-1:0]  wb_tag,
    input  logic [N_WB*DATA_W-1:0] wb_val,
    input  logic                   flush,
    output logic                   commit_valid,
    input  logic                   commit_ready,
    output logic [TAG_W-1:0]       commit_tag,
    output logic [DATA_W-1:0]      commit_val,
    output logic [ADDR_W-1:0]      commit_addr,
    output logic [DEPTH_W:0]       count,
    output logic                   full,
    output logic                   empty,
    output logic [N_WB-1:0]        wb_miss
);
    localparam int DEPTH = 1 << DEPTH_W;

    logic [DEPTH-1:0]   r_busy;
    logic [DEPTH-1:0]   r_done;
    logic [TAG_W-1:0]   r_tag  [DEPTH];
    logic [DATA_W-1:0]  r_val  [DEPTH];
    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DEPTH_W-1:0] r_front;
    logic [DEPTH_W-1:0] r_rear;
    logic [DEPTH_W:0]   r_count;
    logic [N_WB-1:0]    r_wb_miss;

    logic [N_WB-1:0]    w_hit;
    logic [N_WB-1:0]    w_win;
    logic [DEPTH_W-1:0] w_hit_idx [N_WB];
    logic               w_head_ready;
    logic [DATA_W-1:0]  w_head_val;
    logic               w_push_fire;
    logic               w_commit_fire;

    // Oldest-first search: walk from front so duplicate tags resolve to the oldest unsolved entry.
    always_comb begin
        for (int k = 0; k < N_WB; k++) begin
            w_hit[k]     = 1'b0;
            w_hit_idx[k] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!w_hit[k] && wb_valid[k] && ((DEPTH_W+1)'(i) < r_count)
                    && r_busy[r_front + DEPTH_W'(i)] && !r_done[r_front + DEPTH_W'(i)]
                    && (r_tag[r_front + DEPTH_W'(i)] == wb_tag[k*TAG_W +: TAG_W])) begin
                    w_hit[k]     = 1'b1;
                    w_hit_idx[k] = r_front + DEPTH_W'(i);
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_WB; k++) begin
            w_win[k] = w_hit[k];
            for (int j = 0; j < k; j++) begin
                if (w_hit[j] && (w_hit_idx[j] == w_hit_idx[k]))
                    w_win[k] = 1'b0;
            end
        end
    end

`ifdef ROB_WB_BYPASS_EN
    logic              w_byp_hit;
    logic [DATA_W-1:0] w_byp_val;

    always_comb begin
        w_byp_hit = 1'b0;
        w_byp_val = '0;
        for (int k = 0; k < N_WB; k++) begin
            if (w_win[k] && (w_hit_idx[k] == r_front)) begin
                w_byp_hit = 1'b1;
                w_byp_val = wb_val[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_head_ready = r_done[r_front] | w_byp_hit;
    assign w_head_val   = r_done[r_front] ? r_val[r_front] : w_byp_val;
`else
    assign w_head_ready = r_done[r_front];
    assign w_head_val   = r_val[r_front];
`endif

    assign full         = (r_count == (DEPTH_W+1)'(DEPTH));
    assign empty        = (r_count == '0);
    assign count        = r_count;
    assign wb_miss      = r_wb_miss;
    assign push_ready   = rst_in & rdy_in & ~full;
    assign commit_valid = rst_in & rdy_in & r_busy[r_front] & w_head_ready;
    assign commit_tag   = r_tag[r_front];
    assign commit_val   = w_head_val;
    assign commit_addr  = r_addr[r_front];

    // Flush suppresses both fires even though commit_valid may still show the old head.
    assign w_push_fire   = push_valid & push_ready & ~flush;
    assign w_commit_fire = commit_valid & commit_ready & ~flush;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy    <= '0;
            r_done    <= '0;
            r_front   <= '0;
            r_rear    <= '0;
            r_count   <= '0;
            r_wb_miss <= '0;
        end else if (!rdy_in) begin
            r_wb_miss <= '0;
        end else if (flush) begin
            r_busy    <= '0;
            r_done    <= '0;
            r_front   <= '0;
            r_rear    <= '0;
            r_count   <= '0;
            r_wb_miss <= '0;
        end else begin
            r_wb_miss <= wb_valid & ~w_win;
            for (int k = 0; k < N_WB; k++) begin
                if (w_win[k])
                    r_done[w_hit_idx[k]] <= 1'b1;
            end
            if (w_push_fire) begin
                r_busy[r_rear] <= 1'b1;
                r_done[r_rear] <= 1'b0;
                r_rear         <= r_rear + DEPTH_W'(1);
            end
            // Placed after the writeback loop so a bypassed head retires without being marked done.
            if (w_commit_fire) begin
                r_busy[r_front] <= 1'b0;
                r_done[r_front] <= 1'b0;
                r_front         <= r_front + DEPTH_W'(1);
            end
            r_count <= r_count + (DEPTH_W+1)'(w_push_fire) - (DEPTH_W+1)'(w_commit_fire);
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push_fire) begin
            r_tag[r_rear]  <= push_tag;
            r_val[r_rear]  <= '0;
            r_addr[r_rear] <= push_addr;
        end
        if (rst_in && rdy_in && !flush) begin
            for (int k = 0; k < N_WB; k++) begin
                if (w_win[k])
                    r_val[w_hit_idx[k]] <= wb_val[k*DATA_W +: DATA_W];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer_mp.sv
`default_nettype none
// ============================================================================
// Module : tb_reorder_buffer_mp
// Brief  : Directed self-checking bench for reorder_buffer_mp (default params).
// Rev    : 1.0
// ============================================================================
module tb_reorder_buffer_mp;
    localparam int DEPTH_W = 4;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int N_WB    = 2;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic                   rdy_in;
    logic                   push_valid;
    logic                   push_ready;
    logic [TAG_W-1:0]       push_tag;
    logic [ADDR_W-1:0]      push_addr;
    logic [N_WB-1:0]        wb_valid;
    logic [N_WB*TAG_W-1:0]  wb_tag;
    logic [N_WB*DATA_W-1:0] wb_val;
    logic                   flush;
    logic                   commit_valid;
    logic                   commit_ready;
    logic [TAG_W-1:0]       commit_tag;
    logic [DATA_W-1:0]      commit_val;
    logic [ADDR_W-1:0]      commit_addr;
    logic [DEPTH_W:0]       count;
    logic                   full;
    logic                   empty;
    logic [N_WB-1:0]        wb_miss;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    reorder_buffer_mp #(
        .DEPTH_W (DEPTH_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .N_WB    (N_WB)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_tag     (push_tag),
        .push_addr    (push_addr),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_val       (wb_val),
        .flush        (flush),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_tag   (commit_tag),
        .commit_val   (commit_val),
        .commit_addr  (commit_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .wb_miss      (wb_miss)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [TAG_W-1:0] t, input logic [ADDR_W-1:0] a);
        push_valid = 1'b1;
        push_tag   = t;
        push_addr  = a;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wb_set(input int ch, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        wb_valid[ch]               = 1'b1;
        wb_tag[ch*TAG_W +: TAG_W]  = t;
        wb_val[ch*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; push_valid = 1'b0; push_tag = '0; push_addr = '0;
        wb_valid = '0; wb_tag = '0; wb_val = '0; flush = 1'b0; commit_ready = 1'b0;
        #2;
        chk("rst_push_ready", push_ready, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_wb_miss", wb_miss, 0);
        #6 rst_in = 1'b1;
        tick();

        // In-order retire with out-of-order completion
        push(1, 32'h100); push(2, 32'h104); push(3, 32'h108);
        #1;
        chk("t1_count", count, 3);
        chk("t1_cv_idle", commit_valid, 0);
        wb_set(0, 3, 32'h33); tick(); wb_valid = '0;
        wb_set(0, 1, 32'h11); tick(); wb_valid = '0;
        commit_ready = 1'b1; #1;
        chk("t1_cv_tag1", commit_valid, 1);
        chk("t1_tag1", commit_tag, 1);
        chk("t1_val1", commit_val, 32'h11);
        chk("t1_addr1", commit_addr, 32'h100);
        tick(); commit_ready = 1'b0; #1;
        chk("t1_stall_cv", commit_valid, 0);
        chk("t1_stall_tag", commit_tag, 2);
        chk("t1_stall_count", count, 2);
        wb_set(0, 2, 32'h22); tick(); wb_valid = '0;
        commit_ready = 1'b1; #1;
        chk("t1_cv_tag2", commit_valid, 1);
        chk("t1_tag2", commit_tag, 2);
        chk("t1_val2", commit_val, 32'h22);
        tick(); #1;
        chk("t1_cv_tag3", commit_valid, 1);
        chk("t1_tag3", commit_tag, 3);
        chk("t1_val3", commit_val, 32'h33);
        chk("t1_addr3", commit_addr, 32'h108);
        tick(); commit_ready = 1'b0; #1;
        chk("t1_empty", empty, 1);

        // Fill, refuse push when full, wrap, oldest-duplicate writeback
        for (int i = 0; i < 16; i++) push(TAG_W'(i), 32'h200 + 32'(4*i));
        #1;
        chk("t2_full", full, 1);
        chk("t2_push_ready", push_ready, 0);
        chk("t2_count", count, 16);
        push(14, 32'h2F0); #1;
        chk("t2_count_hold", count, 16);
        wb_set(0, 0, 32'h1000); tick(); wb_valid = '0; #1;
        chk("t2_cv_head", commit_valid, 1);
        chk("t2_tag_head", commit_tag, 0);
        commit_ready = 1'b1; tick(); commit_ready = 1'b0; #1;
        chk("t2_full_after", full, 0);
        chk("t2_count_after", count, 15);
        chk("t2_push_ready_after", push_ready, 1);
        push(1, 32'h300); #1;
        chk("t2_refull", full, 1);
        wb_set(0, 1, 32'h77); tick(); wb_valid = '0; #1;
        chk("t2_dup_cv", commit_valid, 1);
        chk("t2_dup_tag", commit_tag, 1);
        chk("t2_dup_addr", commit_addr, 32'h204);
        chk("t2_dup_val", commit_val, 32'h77);
        flush = 1'b1; tick(); flush = 1'b0; #1;
        chk("t2_flush_count", count, 0);

        // Multi-channel writeback and conflicts
        push(5, 32'h400); push(7, 32'h404);
        wb_set(0, 5, 32'hAA); wb_set(1, 7, 32'hBB); tick(); wb_valid = '0; #1;
        chk("t3_no_miss", wb_miss, 2'b00);
        commit_ready = 1'b1; #1;
        chk("t3_cv5", commit_valid, 1);
        chk("t3_val5", commit_val, 32'hAA);
        tick(); #1;
        chk("t3_tag7", commit_tag, 7);
        chk("t3_val7", commit_val, 32'hBB);
        tick(); commit_ready = 1'b0; #1;
        chk("t3_empty", empty, 1);
        push(5, 32'h410);
        wb_set(0, 5, 32'hCC); wb_set(1, 5, 32'hDD); tick(); wb_valid = '0; #1;
        chk("t3_conflict_miss", wb_miss, 2'b10);
        chk("t3_conflict_cv", commit_valid, 1);
        chk("t3_conflict_val", commit_val, 32'hCC);
        wb_set(0, 15, 32'hEE); tick(); wb_valid = '0; #1;
        chk("t3_nomatch_miss", wb_miss, 2'b01);
        tick(); #1;
        chk("t3_miss_pulse", wb_miss, 2'b00);
        commit_ready = 1'b1; tick(); commit_ready = 1'b0; #1;
        chk("t3_empty2", empty, 1);

        // Flush beats push, writeback and commit in the same cycle
        push(1, 32'h500); push(2, 32'h504); push(3, 32'h508); push(4, 32'h50C);
        wb_set(0, 1, 32'h1); wb_set(1, 2, 32'h2); tick(); wb_valid = '0;
        flush = 1'b1; push_valid = 1'b1; push_tag = 6; push_addr = 32'h600;
        wb_set(0, 3, 32'h3); commit_ready = 1'b1; #1;
        chk("t4_cv_preflush", commit_valid, 1);
        tick();
        flush = 1'b0; push_valid = 1'b0; wb_valid = '0; commit_ready = 1'b0; #1;
        chk("t4_count", count, 0);
        chk("t4_empty", empty, 1);
        chk("t4_cv", commit_valid, 0);
        chk("t4_wb_miss", wb_miss, 0);

        // Global hold, then asynchronous reset
        push(8, 32'h700); push(9, 32'h704);
        wb_set(0, 8, 32'h88); tick(); wb_valid = '0;
        rdy_in = 1'b0; push_valid = 1'b1; push_tag = 12; push_addr = 32'h7F0;
        wb_set(1, 9, 32'h99); commit_ready = 1'b1; #1;
        chk("t5_hold_push_ready", push_ready, 0);
        chk("t5_hold_cv", commit_valid, 0);
        repeat (3) tick();
        #1;
        chk("t5_hold_count", count, 2);
        rdy_in = 1'b1; push_valid = 1'b0; wb_valid = '0; commit_ready = 1'b0; #1;
        chk("t5_resume_cv", commit_valid, 1);
        chk("t5_resume_tag", commit_tag, 8);
        chk("t5_resume_miss", wb_miss, 0);
        commit_ready = 1'b1; tick(); commit_ready = 1'b0; #1;
        chk("t5_wb_ignored_cv", commit_valid, 0);
        chk("t5_next_tag", commit_tag, 9);
        push(13, 32'h708); #1;
        chk("t5_rear_count", count, 2);
        #2 rst_in = 1'b0;
        #1;
        chk("t5_arst_count", count, 0);
        chk("t5_arst_empty", empty, 1);
        chk("t5_arst_cv", commit_valid, 0);
        chk("t5_arst_push_ready", push_ready, 0);
        #1 rst_in = 1'b1;
        tick();

        // Writeback straight to an unsolved head
        push(9, 32'h800);
        commit_ready = 1'b1; wb_set(1, 9, 32'h99); #1;
`ifdef ROB_WB_BYPASS_EN
        chk("t6_byp_cv", commit_valid, 1);
        chk("t6_byp_val", commit_val, 32'h99);
        tick(); wb_valid = '0; #1;
        chk("t6_byp_count", count, 0);
`else
        chk("t6_cv_same", commit_valid, 0);
        tick(); wb_valid = '0; #1;
        chk("t6_cv_next", commit_valid, 1);
        chk("t6_val_next", commit_val, 32'h99);
        chk("t6_count_next", count, 1);
        tick(); #1;
        chk("t6_count_done", count, 0);
`endif
        commit_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
